// File: rtl/jk_reg_bank.sv
// Bank of JK flip-flops advanced by an internal rate tick in the clk domain,
// with synchronised j/k inputs, parallel load and a saturating change counter.
module jk_reg_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DIV         = 50000000,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tick,
    output logic [15:0]      chg_cnt
);

    localparam int unsigned     CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
    localparam logic [15:0]     CHG_MAX = 16'hFFFF;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] jk_d;
    logic             tick_q, tick_d;
    logic [15:0]      chg_q, chg_d;
    logic [WIDTH-1:0] j_s, k_s;
    logic             strobe;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign j_s = j;
        assign k_s = k;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][WIDTH-1:0] js_q;
        logic [SYNC_STAGES-1:0][WIDTH-1:0] ks_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                js_q <= '0;
                ks_q <= '0;
            end else begin
                js_q[0] <= j;
                ks_q[0] <= k;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    js_q[i] <= js_q[i-1];
                    ks_q[i] <= ks_q[i-1];
                end
            end
        end

        assign j_s = js_q[SYNC_STAGES-1];
        assign k_s = ks_q[SYNC_STAGES-1];
    end

    assign strobe = en && (cnt_q == CNT_MAX);

    // A load restarts the tick period so the next tick is a full DIV away.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        jk_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({j_s[i], k_s[i]})
                2'b01:   jk_d[i] = 1'b0;
                2'b10:   jk_d[i] = 1'b1;
                2'b11:   jk_d[i] = ~q_q[i];
                default: jk_d[i] = q_q[i];
            endcase
        end
    end

    always_comb begin
        q_d    = q_q;
        tick_d = 1'b0;
        chg_d  = chg_q;
        if (load) begin
            q_d = load_val;
        end else if (strobe) begin
            q_d    = jk_d;
            tick_d = 1'b1;
            if ((jk_d != q_q) && (chg_q != CHG_MAX)) begin
                chg_d = chg_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            q_q    <= RESET_VAL;
            tick_q <= 1'b0;
            chg_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            tick_q <= tick_d;
            chg_q  <= chg_d;
        end
    end

    assign q       = q_q;
    assign qbar    = ~q_q;
    assign tick    = tick_q;
    assign chg_cnt = chg_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Bench for jk_reg_bank: expected tick results are queued as stimulus is
// driven and checked when the DUT raises tick; a DIV=1 copy covers saturation.
module tb_jk_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        rst, en, load, tick;
    logic [3:0]  j, k, load_val, q, qbar;
    logic [15:0] chg;

    logic        rst_f, en_f, load_f, tick_f;
    logic [3:0]  j_f, k_f, lv_f, q_f, qbar_f;
    logic [15:0] chg_f;

    typedef struct packed {
        logic [3:0]  q;
        logic [15:0] chg;
    } exp_t;

    exp_t sb[$];

    jk_reg_bank #(
        .WIDTH(4), .DIV(4), .SYNC_STAGES(2), .RESET_VAL(4'b0000)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .j(j), .k(k),
        .load(load), .load_val(load_val),
        .q(q), .qbar(qbar), .tick(tick), .chg_cnt(chg)
    );

    jk_reg_bank #(
        .WIDTH(4), .DIV(1), .SYNC_STAGES(2), .RESET_VAL(4'b0000)
    ) u_fast (
        .clk(clk), .rst(rst_f), .en(en_f), .j(j_f), .k(k_f),
        .load(load_f), .load_val(lv_f),
        .q(q_f), .qbar(qbar_f), .tick(tick_f), .chg_cnt(chg_f)
    );

    // Returns clk cycles until tick is seen, or -1 after 20 cycles.
    task automatic wait_tick(output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (tick) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        rst = 1'b1; en = 1'b1; j = '0; k = '0;
        load = 1'b0; load_val = '0;
        rst_f = 1'b1; en_f = 1'b1; j_f = 4'hF; k_f = 4'hF;
        load_f = 1'b0; lv_f = '0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (q !== 4'b0000) begin
            fails++; $display("FAIL reset_q q=%b want 0000", q);
        end
        tests++;
        if (qbar !== 4'b1111) begin
            fails++; $display("FAIL reset_qbar qbar=%b want 1111", qbar);
        end
        tests++;
        if (tick !== 1'b0) begin
            fails++; $display("FAIL reset_tick tick=%b want 0", tick);
        end
        tests++;
        if (chg !== 16'd0) begin
            fails++; $display("FAIL reset_chg chg=%h want 0000", chg);
        end
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            sb.push_back('{q: 4'b0000, chg: 16'd0});
            wait_tick(n);
            e = sb.pop_front();
            tests++;
            if (n !== 4) begin
                fails++; $display("FAIL idle_spacing got=%0d want 4", n);
            end
            tests++;
            if (q !== e.q || chg !== e.chg) begin
                fails++;
                $display("FAIL idle_tick q=%b chg=%h want %b %h",
                         q, chg, e.q, e.chg);
            end
        end
    endtask

    task automatic test_jk();
        exp_t e;
        int   n;
        j = 4'b0101; k = 4'b0000;
        sb.push_back('{q: 4'b0101, chg: 16'd1});
        j = 4'b0101;
        wait_tick(n);
        e = sb.pop_front();
        tests++;
        if (n !== 4 || q !== e.q || qbar !== ~e.q || chg !== e.chg) begin
            fails++;
            $display("FAIL jk_set n=%0d q=%b qbar=%b chg=%h want 4 %b %h",
                     n, q, qbar, chg, e.q, e.chg);
        end
        j = 4'b0000; k = 4'b0001;
        sb.push_back('{q: 4'b0100, chg: 16'd2});
        wait_tick(n);
        e = sb.pop_front();
        tests++;
        if (n !== 4 || q !== e.q || qbar !== ~e.q || chg !== e.chg) begin
            fails++;
            $display("FAIL jk_clr n=%0d q=%b qbar=%b chg=%h want 4 %b %h",
                     n, q, qbar, chg, e.q, e.chg);
        end
        // Change two edges before the strobe edge: just in time.
        k = 4'b0000;
        @(negedge clk);
        j = 4'b0010;
        sb.push_back('{q: 4'b0110, chg: 16'd3});
        wait_tick(n);
        e = sb.pop_front();
        tests++;
        if (n !== 3 || q !== e.q || chg !== e.chg) begin
            fails++;
            $display("FAIL sync_in_time n=%0d q=%b chg=%h want 3 %b %h",
                     n, q, chg, e.q, e.chg);
        end
        // Change one edge too late: applies one tick later.
        @(negedge clk);
        @(negedge clk);
        j = 4'b0000; k = 4'b0100;
        sb.push_back('{q: 4'b0110, chg: 16'd3});
        sb.push_back('{q: 4'b0010, chg: 16'd4});
        wait_tick(n);
        e = sb.pop_front();
        tests++;
        if (n !== 2 || q !== e.q || chg !== e.chg) begin
            fails++;
            $display("FAIL sync_late n=%0d q=%b chg=%h want 2 %b %h",
                     n, q, chg, e.q, e.chg);
        end
        wait_tick(n);
        e = sb.pop_front();
        tests++;
        if (n !== 4 || q !== e.q || chg !== e.chg) begin
            fails++;
            $display("FAIL sync_late_next n=%0d q=%b chg=%h want 4 %b %h",
                     n, q, chg, e.q, e.chg);
        end
    endtask

    task automatic test_toggle_freeze();
        exp_t e;
        int   n;
        rst = 1'b1; j = 4'hF; k = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            sb.push_back('{q: (t % 2 == 1) ? 4'b1111 : 4'b0000,
                           chg: 16'(t)});
        end
        for (int t = 1; t <= 5; t++) begin
            wait_tick(n);
            e = sb.pop_front();
            tests++;
            if (n !== 4 || q !== e.q || chg !== e.chg) begin
                fails++;
                $display("FAIL toggle_%0d n=%0d q=%b chg=%h want 4 %b %h",
                         t, n, q, chg, e.q, e.chg);
            end
        end
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (tick !== 1'b0 || q !== 4'b1111) begin
                fails++;
                $display("FAIL freeze_%0d tick=%b q=%b want 0 1111",
                         c, tick, q);
            end
        end
        en = 1'b1;
        sb.push_back('{q: 4'b0000, chg: 16'd6});
        wait_tick(n);
        e = sb.pop_front();
        tests++;
        if (n !== 3 || q !== e.q || chg !== e.chg) begin
            fails++;
            $display("FAIL resume n=%0d q=%b chg=%h want 3 %b %h",
                     n, q, chg, e.q, e.chg);
        end
    endtask

    task automatic test_load();
        exp_t e;
        int   n;
        repeat (3) @(negedge clk);
        load = 1'b1; load_val = 4'b1010;
        @(negedge clk);
        load = 1'b0;
        tests++;
        if (q !== 4'b1010 || tick !== 1'b0 || chg !== 16'd6) begin
            fails++;
            $display("FAIL load_on_strobe q=%b tick=%b chg=%h want 1010 0 0006",
                     q, tick, chg);
        end
        sb.push_back('{q: 4'b0101, chg: 16'd7});
        wait_tick(n);
        e = sb.pop_front();
        tests++;
        if (n !== 4 || q !== e.q || chg !== e.chg) begin
            fails++;
            $display("FAIL after_load n=%0d q=%b chg=%h want 4 %b %h",
                     n, q, chg, e.q, e.chg);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        @(negedge clk);
        rst = 1'b1; load = 1'b1; load_val = 4'b1111;
        @(negedge clk);
        tests++;
        if (q !== 4'b0000 || qbar !== 4'b1111 || tick !== 1'b0
            || chg !== 16'd0) begin
            fails++;
            $display("FAIL rst_over_load q=%b qbar=%b tick=%b chg=%h",
                     q, qbar, tick, chg);
        end
        rst = 1'b0; load = 1'b0; j = '0; k = '0;
        sb.push_back('{q: 4'b0000, chg: 16'd0});
        wait_tick(n);
        e = sb.pop_front();
        tests++;
        if (n !== 4 || q !== e.q || chg !== e.chg) begin
            fails++;
            $display("FAIL rst_restart n=%0d q=%b chg=%h want 4 %b %h",
                     n, q, chg, e.q, e.chg);
        end
    endtask

    task automatic test_saturate();
        bit found;
        logic [3:0] exp_q;
        found = 1'b0;
        rst_f = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (chg_f == 16'hFFFE) begin
                found = 1'b1;
                break;
            end
        end
        tests++;
        if (!found || q_f !== 4'b0000) begin
            fails++;
            $display("FAIL sat_reach found=%0d chg=%h q=%b want FFFE 0000",
                     found, chg_f, q_f);
        end
        exp_q = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (chg_f !== 16'hFFFF || q_f !== exp_q || tick_f !== 1'b1) begin
                fails++;
                $display("FAIL sat_hold_%0d chg=%h q=%b tick=%b want FFFF %b 1",
                         c, chg_f, q_f, tick_f, exp_q);
            end
            exp_q = ~exp_q;
        end
        rst_f = 1'b1;
        @(negedge clk);
        rst_f = 1'b0;
        tests++;
        if (q_f !== 4'b0000 || qbar_f !== 4'b1111 || tick_f !== 1'b0
            || chg_f !== 16'd0) begin
            fails++;
            $display("FAIL sat_reset q=%b qbar=%b tick=%b chg=%h",
                     q_f, qbar_f, tick_f, chg_f);
        end
    endtask

    initial begin
        test_reset();
        test_jk();
        test_toggle_freeze();
        test_load();
        test_reset_mid();
        test_saturate();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
